// File: rtl/register_file.sv
// MIPS 32x32 register file: two combinational read ports, one write port.
// Same-cycle write data is forwarded to matching reads; r0 is hardwired to zero.
module register_file (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  ReadRegister1,
  input  logic [4:0]  ReadRegister2,
  input  logic [4:0]  WriteRegister,
  input  logic [31:0] WriteData,
  input  logic        RegWrite,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2
);

  logic [31:0] r_regs [32];
  logic        w_wen;
  logic        w_byp1;
  logic        w_byp2;

  assign w_wen  = RegWrite && !Reset && (WriteRegister != 5'd0);
  assign w_byp1 = w_wen && (WriteRegister == ReadRegister1);
  assign w_byp2 = w_wen && (WriteRegister == ReadRegister2);

  // r_regs[0] is cleared on reset and never written, so it stays zero
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wen) begin
      r_regs[WriteRegister] <= WriteData;
    end
  end

  always_comb begin
    ReadData1 = '0;
    unique case (1'b1)
      (ReadRegister1 == 5'd0): ReadData1 = '0;
      w_byp1:                  ReadData1 = WriteData;
      default:                 ReadData1 = r_regs[ReadRegister1];
    endcase
  end

  always_comb begin
    ReadData2 = '0;
    unique case (1'b1)
      (ReadRegister2 == 5'd0): ReadData2 = '0;
      w_byp2:                  ReadData2 = WriteData;
      default:                 ReadData2 = r_regs[ReadRegister2];
    endcase
  end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: directed cases plus randomized traffic
// checked against an array model of the architectural register state.
module tb_register_file;

  logic        Clk;
  logic        Reset;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

  register_file dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .ReadRegister1(ReadRegister1),
    .ReadRegister2(ReadRegister2),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData),
    .RegWrite     (RegWrite),
    .ReadData1    (ReadData1),
    .ReadData2    (ReadData2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t        sb_q[$];
  event        ev_sample;
  int          n_tests;
  int          n_fail;
  logic [31:0] model [32];

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (RegWrite && !Reset && WriteRegister == a) return WriteData;
    return model[a];
  endfunction

  task automatic check(input string name);
    exp_t e;
    e.name = name;
    e.e1   = exp_rd(ReadRegister1);
    e.e2   = exp_rd(ReadRegister2);
    sb_q.push_back(e);
    #1;
    ->ev_sample;
    #0;
  endtask

  task automatic tick();
    @(posedge Clk);
    if (!Reset && RegWrite && WriteRegister != 0)
      model[WriteRegister] = WriteData;
    @(negedge Clk);
  endtask

  task automatic drive(input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a1,
                       input logic [4:0] a2);
    RegWrite      = we;
    WriteRegister = wa;
    WriteData     = wd;
    ReadRegister1 = a1;
    ReadRegister2 = a2;
  endtask

  task automatic async_reset();
    #2;
    Reset = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(ev_sample);
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard_empty: got sample with no expectation");
      end else begin
        e = sb_q.pop_front();
        n_tests++;
        if (ReadData1 !== e.e1 || ReadData2 !== e.e2) begin
          n_fail++;
          $display("FAIL %s: rd1=%h rd2=%h expected rd1=%h rd2=%h",
                   e.name, ReadData1, ReadData2, e.e1, e.e2);
        end
      end
    end
  end

  initial begin : stim
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    Reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;

    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);   check("reset_r0");
    drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd4);   check("reset_r4");
    drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd31); check("reset_r31");

    drive(1'b0, 5'd4, 32'd2, 5'd4, 5'd8);
    tick();
    check("guard_we0");
    RegWrite = 1'b1;
    tick();
    RegWrite = 1'b0;
    check("guard_we1");

    drive(1'b1, 5'd10, 32'd25, 5'd10, 5'd4);
    check("bypass_pre");
    tick();
    RegWrite = 1'b0;
    check("bypass_post");

    drive(1'b1, 5'd3, 32'd1, 5'd3, 5'd20);
    check("lastwin_a");
    #2;
    WriteRegister = 5'd20;
    WriteData     = 32'd100;
    check("lastwin_b");
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd20);
    check("lastwin_read");

    drive(1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0);
    check("r0_pre");
    tick();
    check("r0_post");

    for (int a = 8; a <= 25; a++) begin
      drive(1'b1, 5'(a), 32'(a * 32'h1111), 5'd0, 5'd0);
      tick();
    end
    RegWrite = 1'b0;
    for (int a = 8; a <= 24; a += 2) begin
      ReadRegister1 = 5'(a);
      ReadRegister2 = 5'(a + 1);
      check("fill_pair");
    end
    drive(1'b1, 5'd12, 32'h12345678, 5'd12, 5'd25);
    async_reset();
    check("async_reset_now");
    tick();
    check("reset_hold_write");
    Reset = 1'b0;
    RegWrite = 1'b0;
    for (int a = 0; a < 32; a += 2) begin
      ReadRegister1 = 5'(a);
      ReadRegister2 = 5'(a + 1);
      check("post_reset_all");
    end

    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom), $urandom,
            5'($urandom), 5'($urandom));
      if ($urandom_range(0, 3) == 0) ReadRegister1 = WriteRegister;
      if ($urandom_range(0, 3) == 0) ReadRegister2 = WriteRegister;
      check("rand_pre");
      if ($urandom_range(0, 39) == 0) begin
        async_reset();
        check("rand_reset");
        Reset = 1'b0;
        check("rand_reset_rel");
      end
      tick();
    end
    RegWrite = 1'b0;
    for (int a = 0; a < 32; a += 2) begin
      ReadRegister1 = 5'(a);
      ReadRegister2 = 5'(a + 1);
      check("final_dump");
    end

    #2;
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

MIPS 32×32-bit general-purpose register file for the five-stage pipelined datapath. It provides two combinational read ports, consumed in the ID stage, and one synchronous write port, driven from the WB stage. It includes an internal write-to-read bypass, so a value written in WB is visible to an ID-stage read in the same cycle. Register 0 reads as constant zero.

## Interface
Parameters: none. Fixed geometry:
- 32 registers, each 32 bits wide.
- 5-bit register addresses.

Ports:
- Clk  input  1  system clock; all writes occur on its rising edge.
- Reset  input  1  asynchronous, active-high; clears every register to 0.
- ReadRegister1  input  5  address for read port 1 (rs).
- ReadRegister2  input  5  address for read port 2 (rt).
- WriteRegister  input  5  destination address for the write port.
- WriteData  input  32  data to write.
- RegWrite  input  1  write enable, active-high.
- ReadData1  output  32  contents of ReadRegister1, after bypass.
- ReadData2  output  32  contents of ReadRegister2, after bypass.

## Operation
Storage:
- 32 words, regs[0..31], 32 bits each.

Write rule:
- On the rising edge of Clk, if RegWrite=1 and WriteRegister≠0, then regs[WriteRegister] ← WriteData.
- Writes to register 0 are discarded; regs[0] is always 0.
- When RegWrite=0, nothing changes regardless of the other write inputs.

Read rule, evaluated independently for each port p (1 and 2):
- If ReadRegisterp = 0, ReadDatap = 0.
- Else, if RegWrite=1 and WriteRegister = ReadRegisterp, ReadDatap = WriteData (bypass).
- Otherwise, ReadDatap = regs[ReadRegisterp].

Both ports may address the same register, and both receive identical data.

Reset:
- While Reset=1, all 32 registers hold 0. The clear is asynchronous and takes effect immediately, with no clock edge required.
- Writes are suppressed while Reset=1, and the bypass path is disabled, so both outputs read 0.
- Reset overrides any write on the same edge.

No X propagation is permitted after the first Reset: every read of any address returns a defined value.

## Timing
- Read latency: combinational (zero cycles) from the address, WriteData and RegWrite inputs to ReadData1/2.
- Write latency: the value is stored at the rising Clk edge where RegWrite=1.
- Reads see the written value:
  - in the same cycle, through the bypass;
  - from the array in every subsequent cycle.
- Changing WriteRegister or WriteData between edges affects only the bypass output, never the stored state.
  - The last value present at the edge is the one written.
- Reset asserted mid-cycle clears the registers and outputs immediately.
  - The first write after deassertion takes effect at the next rising edge with Reset=0.
- There is no handshake and no stall. The block accepts one write per cycle, every cycle.

## Test plan
1. Reset, then read addresses 0, 4 and 31 on both ports → each returns 0x00000000.
2. Write guard: drive RegWrite=0, WriteRegister=4, WriteData=2 across one edge → reg 4 still reads 0. Then set RegWrite=1 with the same values for one edge, then RegWrite=0 → ReadRegister1=4 gives 2 and ReadRegister2=8 gives 0.
3. Bypass: drive RegWrite=1, WriteRegister=10, WriteData=25 with ReadRegister1=10 → ReadData1=25 before the edge. After the edge, with RegWrite=0, ReadData1 remains 25.
4. Last value wins: within one cycle change WriteRegister/WriteData from 3/1 to 20/100, then take the edge → reg 20 = 100 and reg 3 = 0. Then read ports 3 and 20 → 0 and 100.
5. Register 0 is read-only: write 0xDEADBEEF to register 0 → both ports addressed to 0 read 0, both before and after the edge.
6. Fill and asynchronous reset:
   - Fill registers 8–25 with value = address×0x1111, then read them pairwise (8/9 … 24/25) → each pair matches the written values.
   - Assert Reset between clock edges → both outputs drop to 0 immediately.
   - After deassertion, all registers read 0.
